// File: rtl/xmss_pkg.sv
// Shared XMSS definitions: address bit-field offsets and the FSM state encoding
// used by the seed/key generation blocks.
package xmss_pkg;

  localparam int ADDR_W           = 256;
  localparam int ADDR_FIELD_W     = 32;
  localparam int ADDR_CHAIN_LSB   = 64;
  localparam int ADDR_HASH_LSB    = 32;
  localparam int ADDR_KEYMASK_LSB = 0;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_HASH_START = 3'd1;
  localparam logic [2:0] ST_HASH_WAIT  = 3'd2;
  localparam logic [2:0] ST_WRITE      = 3'd3;
  localparam logic [2:0] ST_DONE       = 3'd4;

  typedef logic [ADDR_W-1:0] xmss_addr_t;

endpackage

// File: rtl/xmss_addr_set.sv
// Overwrites the chain, hash and keyAndMask fields of an XMSS address.
// Purely combinational; every other address bit passes through untouched.
module xmss_addr_set
  import xmss_pkg::*;
(
  input  logic [ADDR_W-1:0]       i_addr,
  input  logic [ADDR_FIELD_W-1:0] i_chain,
  input  logic [ADDR_FIELD_W-1:0] i_hash,
  input  logic [ADDR_FIELD_W-1:0] i_keymask,
  output logic [ADDR_W-1:0]       o_addr
);

  always_comb begin
    o_addr = i_addr;
    o_addr[ADDR_CHAIN_LSB   +: ADDR_FIELD_W] = i_chain;
    o_addr[ADDR_HASH_LSB    +: ADDR_FIELD_W] = i_hash;
    o_addr[ADDR_KEYMASK_LSB +: ADDR_FIELD_W] = i_keymask;
  end

endmodule

// File: rtl/seed_expand.sv
// Expands one secret seed into WOTS_LEN chain secret keys via PRF(seed, addr[chain=i]).
// Latency 1 + WOTS_LEN*(2+H) + 1 cycles inclusive; start ignored while busy, hash_done only in HASH_WAIT.
// Define SEED_EXPAND_SEED_CLEAR_EN to wipe the latched seed and digest in the DONE cycle.
module seed_expand
  import xmss_pkg::*;
#(
  parameter int                 WOTS_LEN              = 67,
  parameter int                 KEY_LEN               = 256,
  parameter logic [KEY_LEN-1:0] XMSS_HASH_PADDING_PRF = KEY_LEN'(3)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [KEY_LEN-1:0]          sec_seed,
  input  logic [ADDR_W-1:0]           hash_addr,
  output logic                        busy,
  output logic                        done,
  output logic                        hash_start,
  output logic [1023:0]               hash_data_in,
  output logic                        message_length,
  input  logic                        hash_done,
  input  logic [KEY_LEN-1:0]          hash_data_out,
  output logic                        seed_mem_wr_en,
  output logic [$clog2(WOTS_LEN)-1:0] seed_mem_wr_addr,
  output logic [KEY_LEN-1:0]          seed_mem_wr_data
);

  localparam int               IDX_W    = $clog2(WOTS_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WOTS_LEN - 1);

  logic [2:0]         r_state;
  logic [IDX_W-1:0]   r_idx;
  logic [KEY_LEN-1:0] r_sec_seed;
  logic [KEY_LEN-1:0] r_digest;
  logic [ADDR_W-1:0]  r_addr;
  logic [ADDR_W-1:0]  w_addr_i;

  xmss_addr_set u_addr_set (
    .i_addr    (r_addr),
    .i_chain   (ADDR_FIELD_W'(r_idx)),
    .i_hash    ('0),
    .i_keymask ('0),
    .o_addr    (w_addr_i)
  );

  // Built only from registers that change outside HASH_WAIT, so the request stays stable.
  assign hash_data_in   = {XMSS_HASH_PADDING_PRF, r_sec_seed, w_addr_i, 256'b0};
  assign message_length = 1'b1;

  assign busy             = (r_state == ST_HASH_START) || (r_state == ST_HASH_WAIT) ||
                            (r_state == ST_WRITE);
  assign done             = (r_state == ST_DONE);
  assign hash_start       = (r_state == ST_HASH_START);
  assign seed_mem_wr_en   = (r_state == ST_WRITE);
  assign seed_mem_wr_addr = r_idx;
  assign seed_mem_wr_data = r_digest;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_idx      <= '0;
      r_sec_seed <= '0;
      r_digest   <= '0;
      r_addr     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_sec_seed <= sec_seed;
            r_addr     <= hash_addr;
            r_idx      <= '0;
            r_state    <= ST_HASH_START;
          end
        end
        ST_HASH_START: r_state <= ST_HASH_WAIT;
        ST_HASH_WAIT: begin
          if (hash_done) begin
            r_digest <= hash_data_out;
            r_state  <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (r_idx == LAST_IDX) begin
            r_state <= ST_DONE;
          end else begin
            r_idx   <= r_idx + 1'b1;
            r_state <= ST_HASH_START;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
`ifdef SEED_EXPAND_SEED_CLEAR_EN
          r_sec_seed <= '0;
          r_digest   <= '0;
`else
          r_sec_seed <= r_sec_seed;
          r_digest   <= r_digest;
`endif
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seed_expand.sv
// Self-checking bench for seed_expand: randomized seeds/addresses, a stand-in PRF responder,
// and a reference model built from the message layout and address-field rules.
module tb_seed_expand;

  localparam int WL = 67;

  logic           clk = 0;
  logic           reset;
  logic           start;
  logic [255:0]   sec_seed;
  logic [255:0]   hash_addr;
  logic           busy, done, hash_start, message_length;
  logic [1023:0]  hash_data_in;
  logic           hash_done = 0;
  logic [255:0]   hash_data_out = '0;
  logic           seed_mem_wr_en;
  logic [6:0]     seed_mem_wr_addr;
  logic [255:0]   seed_mem_wr_data;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int start_cyc, done_cyc;
  int done_cnt = 0;
  int stab_err = 0;
  int hwait = 2;
  bit spur = 0;
  int hcnt = 0;
  logic [1023:0] hreq;

  logic [6:0]    wr_a_q[$];
  logic [255:0]  wr_d_q[$];
  logic [1023:0] req_q[$];

  seed_expand dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .sec_seed         (sec_seed),
    .hash_addr        (hash_addr),
    .busy             (busy),
    .done             (done),
    .hash_start       (hash_start),
    .hash_data_in     (hash_data_in),
    .message_length   (message_length),
    .hash_done        (hash_done),
    .hash_data_out    (hash_data_out),
    .seed_mem_wr_en   (seed_mem_wr_en),
    .seed_mem_wr_addr (seed_mem_wr_addr),
    .seed_mem_wr_data (seed_mem_wr_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Stand-in for the PRF: any fixed mixing of the whole 1024-bit message will do.
  function automatic logic [255:0] fake_prf(input logic [1023:0] m);
    return m[1023:768] ^ {m[766:512], m[767]} ^ (m[511:256] * 256'd40503) ^ {m[127:0], m[255:128]};
  endfunction

  // Expected PRF message: {pad=3, seed, address with chain=i and hash/keyAndMask=0, zeros}.
  function automatic logic [1023:0] exp_msg(input logic [255:0] s, input logic [255:0] a, input int i);
    logic [255:0] keep;
    logic [255:0] ai;
    keep = ~((256'd1 << 96) - 256'd1);
    ai   = (a & keep) | (256'(i) << 64);
    return {256'd3, s, ai, 256'd0};
  endfunction

  function automatic logic [255:0] rand256();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // Hash responder: hash_done lands on the H-th cycle after the hash_start cycle.
  always @(posedge clk) begin
    #1;
    if (!reset) begin
      hcnt = 0;
      hash_done = 0;
    end else begin
      hash_done = 0;
      if (hcnt > 0) begin
        if (hash_data_in !== hreq) stab_err++;
        hcnt--;
        if (hcnt == 0) begin
          hash_done = 1;
          hash_data_out = fake_prf(hreq);
        end
      end
      if (hash_start) begin
        hreq = hash_data_in;
        hcnt = (hwait == 0) ? int'($urandom_range(1, 4)) : hwait;
        if (spur) begin
          hash_done = 1;
          hash_data_out = ~fake_prf(hash_data_in);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      if (seed_mem_wr_en) begin
        wr_a_q.push_back(seed_mem_wr_addr);
        wr_d_q.push_back(seed_mem_wr_data);
      end
      if (hash_start) req_q.push_back(hash_data_in);
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic chk(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_obs();
    wr_a_q.delete();
    wr_d_q.delete();
    req_q.delete();
    done_cnt = 0;
    stab_err = 0;
  endtask

  // Caller is already at a negedge; this drives the start cycle.
  task automatic do_start(input logic [255:0] s, input logic [255:0] a);
    start = 1;
    sec_seed = s;
    hash_addr = a;
    start_cyc = cyc;
    @(negedge clk);
    start = 0;
    sec_seed = rand256();
    hash_addr = rand256();
    #1;
    chk("busy_after_start", busy, 1);
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (done_cnt == 0 && k < 2000) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk({tag, "_done_seen"}, done_cnt != 0, 1);
  endtask

  task automatic wait_writes(input int n);
    int k;
    k = 0;
    while (wr_a_q.size() < n && k < 2000) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("reach_write_count", wr_a_q.size(), n);
  endtask

  task automatic verify_run(input string tag, input logic [255:0] s, input logic [255:0] a);
    chk({tag, "_nwrites"}, wr_a_q.size(), WL);
    chk({tag, "_nreqs"}, req_q.size(), WL);
    chk({tag, "_ndone"}, done_cnt, 1);
    chk({tag, "_req_stable"}, stab_err, 0);
    for (int i = 0; i < WL && i < wr_a_q.size(); i++) begin
      chk($sformatf("%s_waddr%0d", tag, i), wr_a_q[i], i);
      chk($sformatf("%s_wdata%0d", tag, i), wr_d_q[i], fake_prf(exp_msg(s, a, i)));
      if (i < req_q.size()) chk($sformatf("%s_req%0d", tag, i), req_q[i], exp_msg(s, a, i));
    end
  endtask

  initial begin
    logic [255:0] s, a, s2;

    reset = 0;
    start = 0;
    sec_seed = '0;
    hash_addr = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_hash_start", hash_start, 0);
    chk("rst_wr_en", seed_mem_wr_en, 0);
    reset = 1;
    @(negedge clk);
    #1;
    chk("idle_busy", busy, 0);
    chk("idle_msg_len", message_length, 1);

    // Zero seed and address.
    hwait = 2;
    @(negedge clk);
    do_start('0, '0);
    wait_done("zero");
    repeat (3) @(negedge clk);
    verify_run("zero", '0, '0);
    clear_obs();

    // All-ones address, random H, spurious hash_done outside HASH_WAIT.
    hwait = 0;
    spur = 1;
    s = rand256();
    a = '1;
    @(negedge clk);
    do_start(s, a);
    wait_done("ones");
    repeat (3) @(negedge clk);
    verify_run("ones", s, a);
    if (req_q.size() > 5) begin
      chk("ones_addr_low96", req_q[5][351:256], {32'd5, 64'd0});
      chk("ones_addr_upper", req_q[5][511:352], {160{1'b1}});
    end
    clear_obs();
    spur = 0;

    // Second start while busy at i=10 is ignored.
    hwait = 0;
    s = rand256();
    a = rand256();
    @(negedge clk);
    do_start(s, a);
    wait_writes(10);
    @(negedge clk);
    chk("restart_busy", busy, 1);
    start = 1;
    sec_seed = rand256();
    hash_addr = rand256();
    @(negedge clk);
    start = 0;
    wait_done("restart");
    repeat (3) @(negedge clk);
    verify_run("restart", s, a);
    clear_obs();

    // Reset during HASH_WAIT of chain 30, then a clean rerun.
    hwait = 3;
    s = rand256();
    a = rand256();
    @(negedge clk);
    do_start(s, a);
    wait_writes(30);
    @(negedge clk);
    @(negedge clk);
    chk("mid_in_wait_busy", busy, 1);
    chk("mid_in_wait_hs", hash_start, 0);
    reset = 0;
    @(negedge clk);
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_wr_en", seed_mem_wr_en, 0);
    chk("mid_rst_seed_reg", dut.r_sec_seed, 0);
    chk("mid_rst_digest_reg", dut.r_digest, 0);
    @(negedge clk);
    reset = 1;
    clear_obs();
    s = rand256();
    a = rand256();
    @(negedge clk);
    do_start(s, a);
    wait_done("after_rst");
    repeat (3) @(negedge clk);
    verify_run("after_rst", s, a);
    clear_obs();

    // Latency with H=5 (start cycle and done cycle both counted), then back-to-back start.
    hwait = 5;
    s = rand256();
    a = rand256();
    @(negedge clk);
    do_start(s, a);
    wait_done("lat");
    chk("latency_h5", done_cyc - start_cyc + 1, 1 + WL * (2 + 5) + 1);
    chk("done_busy_low", busy, 0);
    verify_run("lat", s, a);
    @(negedge clk);
`ifdef SEED_EXPAND_SEED_CLEAR_EN
    chk("seed_reg_after_done", dut.r_sec_seed, 0);
    chk("digest_reg_after_done", dut.r_digest, 0);
`else
    chk("seed_reg_after_done", dut.r_sec_seed, s);
    chk("digest_reg_after_done", dut.r_digest, fake_prf(exp_msg(s, a, WL - 1)));
`endif
    clear_obs();
    hwait = 0;
    s2 = rand256();
    a = rand256();
    do_start(s2, a);
    wait_done("b2b");
    repeat (3) @(negedge clk);
    verify_run("b2b", s2, a);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
